// File: rtl/sr_flip_flop.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sr_flip_flop
//   Clocked set/reset flip-flop. It holds WIDTH independent storage bits, and
//   each bit is updated on the rising clock edge from its own s/r pair.
//   An asynchronous active-high reset loads RST_VAL into every bit.
//
//   Parameters
//     WIDTH          number of independent SR bits (s, r and q are WIDTH wide)
//     RST_VAL        value loaded into every bit of q while rst=1
//     CONFLICT_MODE  action taken when s=r=1 for a bit:
//                      0 = hold, 1 = force 1, 2 = force 0, 3 = toggle.
//                      Any value above 3 behaves as hold.
//
//   Ports
//     clk  in   1      clock; every change other than reset happens on posedge
//     rst  in   1      asynchronous active-high reset; overrides clk, s and r
//     s    in   WIDTH  per-bit set request, sampled on posedge clk
//     r    in   WIDTH  per-bit clear request, sampled on posedge clk
//     q    out  WIDTH  stored state, driven straight from the flops
// ----------------------------------------------------------------------------
module sr_flip_flop #(
  parameter int unsigned WIDTH         = 1,
  parameter bit          RST_VAL       = 1'b0,
  parameter int unsigned CONFLICT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    CONF_HOLD   = 2'd0,
    CONF_SET    = 2'd1,
    CONF_CLEAR  = 2'd2,
    CONF_TOGGLE = 2'd3
  } conflict_e;

  // The conflict action is fixed at elaboration. Out-of-range modes fall back
  // to hold, so the s=r=1 case always resolves to a known value.
  localparam conflict_e CONFLICT = (CONFLICT_MODE > 3) ? CONF_HOLD
                                   : conflict_e'(CONFLICT_MODE[1:0]);

  logic [WIDTH-1:0] set_only;
  logic [WIDTH-1:0] clr_only;
  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] q_next;

  // Classify each bit's request. At most one of the three masks is set for
  // a given bit.
  assign set_only = s & ~r;
  assign clr_only = r & ~s;
  assign both     = s & r;

  // NOTE: q_next gets a full default before the case statement. No branch
  // can leave it unassigned, so no latch is inferred.
  always_comb begin
    q_next = (q | set_only) & ~clr_only;
    case (CONFLICT)
      CONF_SET:    q_next = q_next | both;
      CONF_CLEAR:  q_next = q_next & ~both;
      CONF_TOGGLE: q_next = q_next ^ both;
      CONF_HOLD:   ;  // conflicting bits keep their current value
      default:     ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments. Every flop then
  // samples values from before the edge, which gives the one-edge latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{RST_VAL}};
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_sr_flip_flop.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_sr_flip_flop
//   Six instances share one clock, one reset and one 4-bit s/r stimulus bus:
//     0..3 : WIDTH=1, CONFLICT_MODE 0..3, RST_VAL 0  (use bit 0 of s/r)
//     4    : WIDTH=4, CONFLICT_MODE 0,    RST_VAL 0
//     5    : WIDTH=4, CONFLICT_MODE 5 (out of range -> hold), RST_VAL 1
//   A per-bit truth-table model follows every instance. The model is checked
//   after each rising edge, and literal expectations pin the directed cases.
// ----------------------------------------------------------------------------
module tb_sr_flip_flop;

  localparam int NINST = 6;
  localparam int WID   [NINST] = '{1, 1, 1, 1, 4, 4};
  localparam int MODE  [NINST] = '{0, 1, 2, 3, 0, 5};
  localparam int RVAL  [NINST] = '{0, 0, 0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] s4  = 4'b0000;
  logic [3:0] r4  = 4'b0000;

  logic       q_m0, q_m1, q_m2, q_m3;
  logic [3:0] q_w4, q_rv1;
  logic [3:0] dq  [NINST];
  logic [3:0] mdl [NINST];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;   // posedges at 5, 15, 25, ...

  sr_flip_flop #(.WIDTH(1), .RST_VAL(1'b0), .CONFLICT_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .s(s4[0:0]), .r(r4[0:0]), .q(q_m0));
  sr_flip_flop #(.WIDTH(1), .RST_VAL(1'b0), .CONFLICT_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .s(s4[0:0]), .r(r4[0:0]), .q(q_m1));
  sr_flip_flop #(.WIDTH(1), .RST_VAL(1'b0), .CONFLICT_MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .s(s4[0:0]), .r(r4[0:0]), .q(q_m2));
  sr_flip_flop #(.WIDTH(1), .RST_VAL(1'b0), .CONFLICT_MODE(3)) u_m3 (
    .clk(clk), .rst(rst), .s(s4[0:0]), .r(r4[0:0]), .q(q_m3));
  sr_flip_flop #(.WIDTH(4), .RST_VAL(1'b0), .CONFLICT_MODE(0)) u_w4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4), .q(q_w4));
  sr_flip_flop #(.WIDTH(4), .RST_VAL(1'b1), .CONFLICT_MODE(5)) u_rv1 (
    .clk(clk), .rst(rst), .s(s4), .r(r4), .q(q_rv1));

  assign dq[0] = {3'b000, q_m0};
  assign dq[1] = {3'b000, q_m1};
  assign dq[2] = {3'b000, q_m2};
  assign dq[3] = {3'b000, q_m3};
  assign dq[4] = q_w4;
  assign dq[5] = q_rv1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Truth table for one bit, written straight from the set/clear/conflict rules.
  function automatic logic next_bit(input int mode, input logic q, input logic s, input logic r);
    if (s && !r) return 1'b1;
    if (r && !s) return 1'b0;
    if (s && r) begin
      case (mode)
        1:       return 1'b1;
        2:       return 1'b0;
        3:       return ~q;
        default: return q;
      endcase
    end
    return q;
  endfunction

  // Model reset: loads the reset value as soon as rst rises.
  always @(posedge rst) begin
    for (int i = 0; i < NINST; i++) begin
      mdl[i] = 4'b0000;
      for (int b = 0; b < WID[i]; b++) mdl[i][b] = RVAL[i][0];
    end
  end

  // Model update on each edge outside reset, then one compare per instance.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < NINST; i++)
        for (int b = 0; b < WID[i]; b++)
          mdl[i][b] = next_bit(MODE[i], mdl[i][b], s4[b], r4[b]);
    end
    #1;
    for (int i = 0; i < NINST; i++) check($sformatf("model_inst%0d", i), dq[i], mdl[i]);
  end

  // Drive s/r on the falling edge, then return 1 unit after the next rising edge.
  task automatic step(input logic [3:0] sv, input logic [3:0] rv);
    @(negedge clk);
    s4 = sv;
    r4 = rv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [3:0] pat_s   [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
  logic [3:0] pat_r   [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
  logic       pat_exp [4] = '{1'b1,    1'b0,    1'b0,    1'b1};

  initial begin
    // Asynchronous reset, applied before any clock edge.
    s4 = 4'b0001;
    r4 = 4'b0000;
    #1 rst = 1'b1;
    #3;                                   // t=4, still before the first posedge
    check("async_reset_m0", dq[0], 4'b0000);
    check("async_reset_w4", dq[4], 4'b0000);
    check("async_reset_rv1", dq[5], 4'b1111);
    #2;                                   // t=6, edge at 5 came while rst=1 and s=1
    check("edge_ignored_in_reset", dq[0], 4'b0000);
    #1 rst = 1'b0;                        // t=7, released between edges

    // Set, then hold over three idle edges.
    step(4'b0001, 4'b0000);
    check("set", dq[0], 4'b0001);
    repeat (3) begin
      step(4'b0000, 4'b0000);
      check("hold", dq[0], 4'b0001);
    end

    // Clear, then wiggle s/r between edges with no effect.
    step(4'b0000, 4'b0001);
    check("clear", dq[0], 4'b0000);
    s4 = 4'b0001;
    r4 = 4'b0000;
    #2;
    check("no_edge_no_change", dq[0], 4'b0000);

    // Async reset from q=1 mid-cycle, then an edge with s=1 while still in reset.
    step(4'b0001, 4'b0000);
    check("set_again", dq[0], 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("async_reset_midcycle", dq[0], 4'b0000);
    @(negedge clk);
    s4 = 4'b0001;
    r4 = 4'b0000;
    @(posedge clk);
    #1;
    check("set_blocked_by_reset", dq[0], 4'b0000);
    #2 rst = 1'b0;

    // Conflict handling, starting from q=1 in every mode.
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0001);
    check("conflict_hold", dq[0], 4'b0001);
    check("conflict_force1", dq[1], 4'b0001);
    check("conflict_force0", dq[2], 4'b0000);
    check("conflict_toggle1", dq[3], 4'b0000);
    step(4'b0001, 4'b0001);
    check("conflict_toggle2", dq[3], 4'b0001);
    check("conflict_force0_again", dq[2], 4'b0000);

    // Four-bit instance: load 1010, then apply mixed per-bit requests.
    step(4'b1010, 4'b0101);
    check("w4_load", dq[4], 4'b1010);
    // bit3 idle holds 1, bit2 cleared, bit1 set, bit0 conflict holds 0
    step(4'b0011, 4'b0101);
    check("w4_mixed", dq[4], 4'b1010);
    check("rv1_mixed", dq[5], 4'b1010);

    // Reset toggling every 5 units: high around each negedge, low around each posedge.
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s4 = pat_s[k];
      r4 = pat_r[k];
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("toggle_rst_edge%0d", k), dq[0], {3'b000, pat_exp[k]});
      #1 rst = 1'b1;
      #1;
      check($sformatf("toggle_rst_rise%0d", k), dq[0], 4'b0000);
    end
    @(negedge clk);
    #2 rst = 1'b0;

    // Random traffic, with occasional reset pulses placed between edges.
    repeat (400) begin
      @(negedge clk);
      s4 = 4'($urandom);
      r4 = 4'($urandom);
      #2 rst = 1'b0;
      @(posedge clk);
      #3;
      if ($urandom_range(15) == 0) begin
        rst = 1'b1;
        #1;
        for (int i = 0; i < NINST; i++) check($sformatf("rand_reset_inst%0d", i), dq[i], mdl[i]);
      end
    end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
